if_id_stage: RTL
================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 Parameter MEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-002 Parameter HALT_WORD, default 32'hFFFFFFFF, encoding that halts fetch.
REQ-003 Parameter NOP_WORD, default 32'h00000000, bubble encoding.
REQ-004 i_clk  input  1  single clock; all state updates on rising edge.
REQ-005 i_reset  input  1  synchronous, active-high reset.
REQ-006 i_pc  input  32  byte address of instruction to fetch this cycle.
REQ-007 i_stall  input  1  hazard stall; IF/ID register holds.
REQ-008 i_flush  input  1  taken jump resolved downstream; squash fetched instruction.
REQ-009 i_load_mode  input  1  debug unit owns memory; pipeline frozen.
REQ-010 i_wr_en  input  1  memory write strobe, honoured only while i_load_mode=1.
REQ-011 i_wr_addr  input  $clog2(MEM_WORDS)  word address of write.
REQ-012 i_wr_data  input  32  instruction word to write.
REQ-013 o_instruction  output  32  IF/ID instruction register.
REQ-014 o_pc_plus4  output  32  IF/ID copy of i_pc+4.
REQ-015 o_valid  output  1  IF/ID holds a real fetched instruction.
REQ-016 o_halt  output  1  sticky; HALT_WORD captured into IF/ID; drives program counter i_halt.
REQ-017 o_addr_error  output  1  sticky; fetch attempted beyond memory.

Function
REQ-018 Memory read is combinational at word index i_pc[log2(4*MEM_WORDS)-1:2]; i_pc[1:0] ignored.
REQ-019 If any i_pc bit at or above log2(4*MEM_WORDS) is set, fetched word is NOP_WORD and o_addr_error sets next edge.
REQ-020 Fetch-to-IF/ID latency is exactly one cycle: word at i_pc in cycle N appears on o_instruction after edge N.
REQ-021 Update priority per edge: reset > load_mode > flush > (stall or o_halt) > capture.
REQ-022 Load mode: IF/ID loads NOP_WORD, o_pc_plus4=0, o_valid=0; write performed if i_wr_en.
REQ-023 Writes with i_load_mode=0 are ignored; memory contents unchanged.
REQ-024 Flush: IF/ID loads NOP_WORD, o_pc_plus4=0, o_valid=0, regardless of i_stall.
REQ-025 Stall or o_halt=1 without flush: IF/ID, o_valid hold previous values.
REQ-026 Capture: o_instruction=fetched word, o_pc_plus4=i_pc+32'd4 (mod 2^32), o_valid=1.
REQ-027 o_halt sets on the edge that captures HALT_WORD; thereafter no capture until reset.
REQ-028 Flush and HALT fetch in same cycle: NOP captured, o_halt stays 0.
REQ-029 Stall with HALT at i_pc: HALT not captured, o_halt stays 0 until captured.
REQ-030 Write and read of same word in one cycle: read returns old content; new content visible next cycle.

Reset
REQ-031 Reset: o_instruction=NOP_WORD, o_pc_plus4=0, o_valid=0, o_halt=0, o_addr_error=0.
REQ-032 Reset does not clear instruction memory; a loaded program survives reset.
REQ-033 Reset mid-stall or mid-halt exits immediately; capture resumes the following edge if no freeze input active.

Structure
REQ-034 NOP_WORD, HALT_WORD, instruction width and default MEM_WORDS live in shared package mips_pkg.
REQ-035 Memory array is sub-module instruction_memory (sync write, async read); IF/ID register and flags stay in if_id_stage.

Verification
REQ-036 Load 0x20010005 at word 0, 0xFFFFFFFF at word 1, leave load mode, reset, i_pc=0 -> o_instruction=0x20010005, o_pc_plus4=4, o_valid=1 after one edge.
REQ-037 i_pc=4 next cycle -> o_instruction=0xFFFFFFFF, o_halt=1; change i_pc to 8 -> outputs hold indefinitely.
REQ-038 i_stall=1 for 3 cycles with i_pc changing -> o_instruction, o_pc_plus4 unchanged; release -> capture current word.
REQ-039 i_flush=1 and i_stall=1 together -> o_instruction=0, o_valid=0, o_pc_plus4=0.
REQ-040 i_pc=0x00000400 (MEM_WORDS=256) -> o_instruction=0, o_addr_error=1 sticky until reset.
REQ-041 i_wr_en=1 with i_load_mode=0 at word 2 -> subsequent fetch of i_pc=8 returns previously loaded word.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: instruction width, special encodings, default memory depth.
package mips_pkg;

    localparam int unsigned INSTR_W           = 32;
    localparam int unsigned DEFAULT_MEM_WORDS = 256;

    typedef logic [INSTR_W-1:0] word_t;

    localparam word_t NOP_WORD  = 32'h0000_0000;
    localparam word_t HALT_WORD = 32'hFFFF_FFFF;

    // True when any byte-address bit at or above byte_aw is set.
    function automatic logic pc_out_of_range(input word_t pc, input int unsigned byte_aw);
        return (pc >> byte_aw) != '0;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Instruction store: synchronous write port, asynchronous read port, never cleared by reset.
module instruction_memory
    import mips_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
)(
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [$clog2(MEM_WORDS)-1:0] i_waddr,
    input  word_t                        i_wdata,
    input  logic [$clog2(MEM_WORDS)-1:0] i_raddr,
    output word_t                        o_rdata
);

    word_t r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read sees pre-edge contents, so a same-cycle write is visible only next cycle.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/if_id_stage.sv
// Fetch stage plus IF/ID pipeline register with halt and address-error flags.
module if_id_stage #(
    parameter int unsigned     MEM_WORDS = mips_pkg::DEFAULT_MEM_WORDS,
    parameter mips_pkg::word_t HALT_WORD = mips_pkg::HALT_WORD,
    parameter mips_pkg::word_t NOP_WORD  = mips_pkg::NOP_WORD
)(
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [31:0]                  i_pc,
    input  logic                         i_stall,
    input  logic                         i_flush,
    input  logic                         i_load_mode,
    input  logic                         i_wr_en,
    input  logic [$clog2(MEM_WORDS)-1:0] i_wr_addr,
    input  logic [31:0]                  i_wr_data,
    output logic [31:0]                  o_instruction,
    output logic [31:0]                  o_pc_plus4,
    output logic                         o_valid,
    output logic                         o_halt,
    output logic                         o_addr_error
);

    localparam int unsigned AW  = $clog2(MEM_WORDS);
    localparam int unsigned BAW = AW + 2;

    logic            w_oob;
    logic            w_mem_we;
    logic [AW-1:0]   w_raddr;
    mips_pkg::word_t w_mem_word;
    mips_pkg::word_t w_fetch;

    mips_pkg::word_t r_instruction;
    logic [31:0]     r_pc_plus4;
    logic            r_valid;
    logic            r_halt;
    logic            r_addr_error;

    assign w_oob    = mips_pkg::pc_out_of_range(i_pc, BAW);
    assign w_raddr  = i_pc[BAW-1:2];
    assign w_mem_we = i_load_mode & i_wr_en;
    assign w_fetch  = w_oob ? NOP_WORD : w_mem_word;

    instruction_memory #(
        .MEM_WORDS (MEM_WORDS)
    ) u_imem (
        .i_clk   (i_clk),
        .i_we    (w_mem_we),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data),
        .i_raddr (w_raddr),
        .o_rdata (w_mem_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_instruction <= NOP_WORD;
            r_pc_plus4    <= '0;
            r_valid       <= 1'b0;
            r_halt        <= 1'b0;
            r_addr_error  <= 1'b0;
        end else begin
            if (w_oob) begin
                r_addr_error <= 1'b1;
            end
            if (i_load_mode || i_flush) begin
                r_instruction <= NOP_WORD;
                r_pc_plus4    <= '0;
                r_valid       <= 1'b0;
            end else if (!(i_stall || r_halt)) begin
                r_instruction <= w_fetch;
                r_pc_plus4    <= i_pc + 32'd4;
                r_valid       <= 1'b1;
                if (w_fetch == HALT_WORD) begin
                    r_halt <= 1'b1;
                end
            end
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc_plus4    = r_pc_plus4;
    assign o_valid       = r_valid;
    assign o_halt        = r_halt;
    assign o_addr_error  = r_addr_error;

endmodule
